// File: rtl/signed_add_arbiter.sv
// signed_add_arbiter
// Two requesters share one registered signed adder. Round-robin arbitration picks one
// requester per cycle; the sum, its overflow flag and the winning requester's index land
// in a one-entry output register with valid/ready backpressure. An optional saturation
// mode clamps overflowing sums, and a saturating counter tallies overflowing operations.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req{0,1}_vld/_a/_b/_rdy      request handshakes with signed operands
//   res_vld/_sum/_overflow/_id   result register contents
//   res_rdy                      downstream consumer takes the result
//   ovf_clr, ovf_cnt             synchronous counter clear, overflow count
module signed_add_arbiter #(
  parameter int unsigned WIDTH    = 4,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_vld,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_rdy,
  input  logic             req1_vld,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_rdy,
  output logic             res_vld,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_overflow,
  output logic             res_id,
  input  logic             res_rdy,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               ovf_q, ovf_d;
  logic               id_q, id_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               grant0, grant1;
  logic               xfer;
  logic [WIDTH-1:0]   op_a, op_b, raw, sat_val;
  logic               ovf;

  // With both valid, last_grant_q=1 means requester 1 went last, so requester 0 wins.
  assign accept   = (state_q == StEmpty) | res_rdy;
  assign grant0   = req0_vld & (~req1_vld | last_grant_q);
  assign grant1   = req1_vld & (~req0_vld | ~last_grant_q);
  assign req0_rdy = accept & grant0;
  assign req1_rdy = accept & grant1;
  assign xfer     = req0_rdy | req1_rdy;

  assign op_a = req1_rdy ? req1_a : req0_a;
  assign op_b = req1_rdy ? req1_b : req0_b;
  assign raw  = op_a + op_b;
  assign ovf  = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (raw[WIDTH-1] != op_a[WIDTH-1]);
  // Clamp toward the sign of the operands: max positive or min negative.
  assign sat_val = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    ovf_d        = ovf_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;

    if (xfer) begin
      state_d      = StFull;
      sum_d        = (SATURATE && ovf) ? sat_val : raw;
      ovf_d        = ovf;
      id_d         = req1_rdy;
      last_grant_d = req1_rdy;
    end else if (res_rdy) begin
      state_d = StEmpty;
    end

    if (ovf_clr) begin
      cnt_d = '0;
    end else if (xfer && ovf && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      sum_q        <= '0;
      ovf_q        <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      ovf_q        <= ovf_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign res_vld      = (state_q == StFull);
  assign res_sum      = sum_q;
  assign res_overflow = ovf_q;
  assign res_id       = id_q;
  assign ovf_cnt      = cnt_q;

endmodule

// File: tb/tb_signed_add_arbiter.sv
module tb_signed_add_arbiter;
  localparam int W = 4;
  localparam int C = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req0_vld, req1_vld, res_rdy, ovf_clr;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;

  // w_*: wrapping instance, s_*: saturating instance
  logic         w_req0_rdy, w_req1_rdy, w_res_vld, w_res_ovf, w_res_id;
  logic [W-1:0] w_res_sum;
  logic [C-1:0] w_ovf_cnt;
  logic         s_req0_rdy, s_req1_rdy, s_res_vld, s_res_ovf, s_res_id;
  logic [W-1:0] s_res_sum;
  logic [C-1:0] s_ovf_cnt;

  signed_add_arbiter #(.WIDTH(W), .SATURATE(1'b0), .CNT_W(C)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_a(req0_a), .req0_b(req0_b), .req0_rdy(w_req0_rdy),
    .req1_vld(req1_vld), .req1_a(req1_a), .req1_b(req1_b), .req1_rdy(w_req1_rdy),
    .res_vld(w_res_vld), .res_sum(w_res_sum), .res_overflow(w_res_ovf), .res_id(w_res_id),
    .res_rdy(res_rdy), .ovf_clr(ovf_clr), .ovf_cnt(w_ovf_cnt)
  );

  signed_add_arbiter #(.WIDTH(W), .SATURATE(1'b1), .CNT_W(C)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_a(req0_a), .req0_b(req0_b), .req0_rdy(s_req0_rdy),
    .req1_vld(req1_vld), .req1_a(req1_a), .req1_b(req1_b), .req1_rdy(s_req1_rdy),
    .res_vld(s_res_vld), .res_sum(s_res_sum), .res_overflow(s_res_ovf), .res_id(s_res_id),
    .res_rdy(res_rdy), .ovf_clr(ovf_clr), .ovf_cnt(s_ovf_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: result slot contents, round-robin pointer, overflow tally.
  bit         m_vld, m_ovf, m_id, m_last;
  logic [W-1:0] m_wsum, m_ssum;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_ovf = 0; m_id = 0; m_last = 1; m_cnt = 0;
    m_wsum = '0; m_ssum = '0;
  endtask

  task automatic drive(input bit v0, input int a0, input int b0, input bit v1, input int a1,
                       input int b1, input bit rr, input bit clr);
    req0_vld = v0; req0_a = W'(a0); req0_b = W'(b0);
    req1_vld = v1; req1_a = W'(a1); req1_b = W'(b1);
    res_rdy = rr; ovf_clr = clr;
  endtask

  task automatic check_out();
    chk("w_res_vld", w_res_vld, m_vld);
    chk("s_res_vld", s_res_vld, m_vld);
    if (m_vld) begin
      chk("w_res_sum", w_res_sum, m_wsum);
      chk("s_res_sum", s_res_sum, m_ssum);
      chk("w_res_overflow", w_res_ovf, m_ovf);
      chk("s_res_overflow", s_res_ovf, m_ovf);
      chk("w_res_id", w_res_id, m_id);
      chk("s_res_id", s_res_id, m_id);
    end
    chk("w_ovf_cnt", w_ovf_cnt, m_cnt);
    chk("s_ovf_cnt", s_ovf_cnt, m_cnt);
  endtask

  // One clock: check ready at the negedge, predict, check outputs just after the posedge.
  task automatic cycle();
    bit acc, g0, g1;
    int sa, sb, s;
    @(negedge clk);
    acc = !m_vld || res_rdy;
    if (req0_vld && req1_vld) begin
      g0 = acc && m_last;
      g1 = acc && !m_last;
    end else begin
      g0 = acc && req0_vld;
      g1 = acc && req1_vld;
    end
    chk("w_req0_rdy", w_req0_rdy, g0);
    chk("w_req1_rdy", w_req1_rdy, g1);
    chk("s_req0_rdy", s_req0_rdy, g0);
    chk("s_req1_rdy", s_req1_rdy, g1);
    @(posedge clk);
    #1;
    if (g0 || g1) begin
      sa = g1 ? $signed(req1_a) : $signed(req0_a);
      sb = g1 ? $signed(req1_b) : $signed(req0_b);
      s = sa + sb;
      m_ovf = (s > 7) || (s < -8);
      m_wsum = s[W-1:0];
      if (s > 7) m_ssum = 4'b0111;
      else if (s < -8) m_ssum = 4'b1000;
      else m_ssum = s[W-1:0];
      m_id = g1;
      m_last = g1;
      m_vld = 1;
      if (ovf_clr) m_cnt = 0;
      else if (m_ovf && m_cnt < 255) m_cnt++;
    end else begin
      if (ovf_clr) m_cnt = 0;
      if (res_rdy) m_vld = 0;
    end
    check_out();
  endtask

  initial begin
    // Reset state; ready is combinational and visible while in reset.
    model_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check_out();
    chk("reset_req0_rdy", w_req0_rdy, 1);
    chk("reset_req1_rdy", w_req1_rdy, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request: 4 + 7 wraps to -5 with overflow.
    drive(1, 4, 7, 0, 0, 0, 1, 0);
    cycle();
    chk("single_sum", w_res_sum, 4'b1011);
    chk("single_ovf", w_res_ovf, 1);
    chk("single_id", w_res_id, 0);
    chk("single_cnt", w_ovf_cnt, 1);

    // Contention: alternating grants.
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, -2, 1, -4, -4, 1, 0);
      cycle();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, $urandom_range(15), $urandom_range(15), 1, $urandom_range(15),
            $urandom_range(15), 1, 0);
      cycle();
    end

    // Backpressure: result held, no grants, then resume from saved pointer.
    for (int i = 0; i < 6; i++) begin
      drive(1, 2, 3, 1, -1, -1, 0, 0);
      cycle();
    end
    chk("bp_hold_rdy0", w_req0_rdy, 0);
    chk("bp_hold_rdy1", w_req1_rdy, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 2, 3, 1, -1, -1, 1, 0);
      cycle();
    end

    // Saturation corner cases.
    drive(1, 7, 4, 0, 0, 0, 1, 0);   cycle();
    chk("sat_7p4", s_res_sum, 4'd7);
    drive(1, -4, -7, 0, 0, 0, 1, 0); cycle();
    chk("sat_m4m7", s_res_sum, 4'b1000);
    drive(1, -3, -5, 0, 0, 0, 1, 0); cycle();
    chk("sat_m3m5_ovf", s_res_ovf, 0);
    drive(1, 3, -5, 0, 0, 0, 1, 0);  cycle();
    chk("sat_3m5", s_res_sum, 4'b1110);
    drive(0, 0, 0, 0, 0, 0, 1, 0);   cycle();

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(1), $urandom_range(15), $urandom_range(15), $urandom_range(1),
            $urandom_range(15), $urandom_range(15), $urandom_range(3) != 0,
            $urandom_range(15) == 0);
      cycle();
    end

    // Counter saturation, then clear beats a simultaneous increment.
    for (int i = 0; i < 300; i++) begin
      drive(1, 7, 7, 0, 0, 0, 1, 0);
      cycle();
    end
    chk("cnt_sat", w_ovf_cnt, 255);
    drive(1, 7, 7, 0, 0, 0, 1, 1);
    cycle();
    chk("cnt_clr", w_ovf_cnt, 0);

    // Reset mid-operation while full with a pending request.
    drive(1, 5, 5, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 1, 1, 1, 2, 2, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vld_w", w_res_vld, 0);
    chk("rst_mid_vld_s", s_res_vld, 0);
    chk("rst_mid_cnt", w_ovf_cnt, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 1, 1, 1, 2, 2, 1, 0);
    cycle();
    chk("rst_first_grant", w_res_id, 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Global guard so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
